// File: rtl/ifetch_axi_bridge_pkg.sv
// ifetch_axi_bridge_pkg: shared FSM encodings and constants for the IF-to-AXI4-Lite fetch bridge.
package ifetch_axi_bridge_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, HOLD = 2'd3} state_t;
    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/ifetch_axi_bridge_if.sv
// ifetch_axi_bridge_if: IF-side fetch port and AXI4-Lite read channels seen by the bridge.
interface ifetch_axi_bridge_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic [31:0]       s_rdata;
    logic              s_rvalid;
    logic              s_rerr;
    logic              s_rready;
    logic [ADDR_W-1:0] m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [31:0]       m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;
    modport master (
        input  s_araddr, s_arvalid, s_rready, m_arready, m_rdata, m_rresp, m_rvalid,
        output s_rdata, s_rvalid, s_rerr, m_araddr, m_arvalid, m_rready
    );
    modport slave (
        output s_araddr, s_arvalid, s_rready, m_arready, m_rdata, m_rresp, m_rvalid,
        input  s_rdata, s_rvalid, s_rerr, m_araddr, m_arvalid, m_rready
    );
endinterface

// File: rtl/ifetch_axi_bridge.sv
// ifetch_axi_bridge: turns IF's level-held fetch request into one AXI4-Lite read and holds the word until consumed.
module ifetch_axi_bridge
    import ifetch_axi_bridge_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 flush,
    ifetch_axi_bridge_if.master bus
);
    state_t              r_state, w_state_nx;
    logic [ADDR_W-1:0]   r_addr, w_addr_nx;
    logic [31:0]         r_data, w_data_nx;
    logic                r_err, w_err_nx;
    logic                r_drop, w_drop_nx;
    logic                w_ok;

    assign w_ok = bus.m_rresp == AXI_RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_addr  <= w_addr_nx;
            r_data  <= w_data_nx;
            r_err   <= w_err_nx;
            r_drop  <= w_drop_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        w_err_nx   = r_err;
        w_drop_nx  = r_drop;
        case (r_state)
            IDLE: if (bus.s_arvalid && !flush) begin
                w_addr_nx = bus.s_araddr;
                if (bus.s_araddr[1:0] == 2'b00) w_state_nx = ADDR;
                else begin
                    w_state_nx = HOLD;
                    w_data_nx  = NOP_WORD;
                    w_err_nx   = 1'b1;
                end
            end
            // A flushed address phase must still finish; its beat is dropped later.
            ADDR: begin
                w_drop_nx = r_drop | flush;
                if (bus.m_arready) w_state_nx = DATA;
            end
            DATA: begin
                w_drop_nx = r_drop | flush;
                if (bus.m_rvalid) begin
                    w_drop_nx  = 1'b0;
                    w_state_nx = (r_drop || flush) ? IDLE : HOLD;
                    if (!(r_drop || flush)) begin
                        w_data_nx = w_ok ? bus.m_rdata : NOP_WORD;
                        w_err_nx  = !w_ok;
                    end
                end
            end
            HOLD: if (flush || bus.s_rready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.m_arvalid = r_state == ADDR;
        bus.m_araddr  = r_addr;
        bus.m_rready  = r_state == DATA;
        bus.s_rvalid  = r_state == HOLD;
        bus.s_rdata   = r_data;
        bus.s_rerr    = r_err;
    end
endmodule
